// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for the 24-bit multi-cycle computer.
// Decodes the current opcode (low 4 bits) into IR/PC/regfile/ALU-mux/memory
// controls and sequences each instruction through FETCH..writeback states.
// It waits on variable-latency instruction/data memories and gives up with
// ERROR after MEM_TIMEOUT wait cycles (0 = wait forever). It also counts
// retired instructions.
//
// Handshake: a request (imem_req_o / dmem_req_o) stays high for as long as the
// sequencer sits in FETCH / MEM_ACCESS. The access completes on the first
// rising clock edge where the matching ready input is high, and the sequencer
// leaves the state on that edge. Ready is ignored while no request is raised.
//
// Ports:
//   clock_i, reset_i (async, active-high)   clock and reset
//   opcode_i, zero_i                        instruction opcode, ALU zero flag
//   imem_ready_i, dmem_ready_i              memory completion strobes
//   imem_req_o, dmem_req_o                  memory requests
//   mem_read_not_write_o                    1 = read, 0 = write
//   ir_write_o, pc_write_o, pc_source_o     IR / PC load controls
//   alu_src_a_o, alu_src_b_o, alu_op_o      ALU operand and operation selects
//   reg_write_o, mem_to_reg_o               register-file write controls
//   state_out_o, halted_o, error_o          state debug view and terminal flags
//   retired_o                               retired-instruction count (wraps)
module mc_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int MEM_TIMEOUT  = 15,
  parameter int RETIRE_WIDTH = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic                    zero_i,
  input  logic                    imem_ready_i,
  input  logic                    dmem_ready_i,
  output logic                    imem_req_o,
  output logic                    dmem_req_o,
  output logic                    mem_read_not_write_o,
  output logic                    ir_write_o,
  output logic                    pc_write_o,
  output logic [1:0]              pc_source_o,
  output logic                    alu_src_a_o,
  output logic [1:0]              alu_src_b_o,
  output logic [2:0]              alu_op_o,
  output logic                    reg_write_o,
  output logic                    mem_to_reg_o,
  output logic [3:0]              state_out_o,
  output logic                    halted_o,
  output logic                    error_o,
  output logic [RETIRE_WIDTH-1:0] retired_o
);

  typedef enum logic [3:0] {
    S_INIT       = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC_R     = 4'd3,
    S_EXEC_I     = 4'd4,
    S_MEM_ADDR   = 4'd5,
    S_MEM_ACCESS = 4'd6,
    S_WB_ALU     = 4'd7,
    S_WB_MEM     = 4'd8,
    S_BRANCH     = 4'd9,
    S_JUMP       = 4'd10,
    S_HALTED     = 4'd11,
    S_ERROR      = 4'd12
  } state_e;

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        wait_q, wait_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;

  logic [3:0] op4;
  logic       timeout_hit;
  logic       waiting;
  logic       retire;

  assign op4 = opcode_i[3:0];
  // Ready in the same cycle as the limit takes priority, so this only matters
  // on the ready-low path below.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_INIT;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    waiting              = 1'b0;
    retire               = 1'b0;
    imem_req_o           = 1'b0;
    dmem_req_o           = 1'b0;
    mem_read_not_write_o = 1'b1;
    ir_write_o           = 1'b0;
    pc_write_o           = 1'b0;
    pc_source_o          = 2'd0;
    alu_src_a_o          = 1'b0;
    alu_src_b_o          = 2'd0;
    alu_op_o             = 3'd0;
    reg_write_o          = 1'b0;
    mem_to_reg_o         = 1'b0;

    unique case (state_q)
      S_INIT: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'd3;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o  = 1'b1;
        alu_src_b_o = 2'd1;               // PC + 1
        if (imem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'd2;               // branch target into ALU-out
        case (op4)
          4'd0, 4'd1, 4'd2, 4'd3: state_d = S_EXEC_R;
          4'd4:                   state_d = S_EXEC_I;
          4'd5, 4'd6:             state_d = S_MEM_ADDR;
          4'd7, 4'd8:             state_d = S_BRANCH;
          4'd9:                   state_d = S_JUMP;
          4'd15: begin
            state_d = S_HALTED;
            retire  = 1'b1;
          end
          default:                state_d = S_ERROR;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = {1'b0, op4[1:0]};
        state_d     = S_WB_ALU;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        state_d     = (state_q == S_EXEC_I) ? S_WB_ALU : S_MEM_ACCESS;
      end
      S_MEM_ACCESS: begin
        dmem_req_o           = 1'b1;
        mem_read_not_write_o = (op4 == 4'd5);
        if (dmem_ready_i) begin
          if (op4 == 4'd5) begin
            state_d = S_WB_MEM;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (state_q == S_WB_MEM);
        state_d      = S_FETCH;
        retire       = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'd1;
        pc_source_o = 2'd1;
        pc_write_o  = (op4 == 4'd7) ? zero_i : !zero_i;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'd2;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_HALTED: state_d = S_HALTED;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase

    // The counter only runs while a request is stalled; any state change restarts it.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
    retired_d = retired_q + RETIRE_WIDTH'(retire);
  end

  assign state_out_o = state_q;
  assign halted_o    = (state_q == S_HALTED);
  assign error_o     = (state_q == S_ERROR);
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
module tb_mc_sequencer;
  localparam int OW = 4;
  localparam int TO = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [OW-1:0] opcode = '0;
  logic          zero = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          imem_req, dmem_req, mrnw, ir_write, pc_write;
  logic [1:0]    pc_source, alu_src_b;
  logic          alu_src_a, reg_write, mem_to_reg, halted, error;
  logic [2:0]    alu_op;
  logic [3:0]    state_out;
  logic [RW-1:0] retired;
  logic [16:0]   ctrl;

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;

  // Planned cycles of the current instruction: state, ready inputs, retire flag.
  int sq[$];
  bit iq[$];
  bit dq[$];
  bit rq[$];

  mc_sequencer #(.OPCODE_WIDTH(OW), .MEM_TIMEOUT(TO), .RETIRE_WIDTH(RW)) dut (
    .clock_i(clk), .reset_i(rst), .opcode_i(opcode), .zero_i(zero),
    .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
    .imem_req_o(imem_req), .dmem_req_o(dmem_req), .mem_read_not_write_o(mrnw),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_source_o(pc_source),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .reg_write_o(reg_write), .mem_to_reg_o(mem_to_reg), .state_out_o(state_out),
    .halted_o(halted), .error_o(error), .retired_o(retired)
  );

  assign ctrl = {imem_req, dmem_req, mrnw, ir_write, pc_write, pc_source, alu_src_a,
                 alu_src_b, alu_op, reg_write, mem_to_reg, halted, error};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output table: what each state drives, taken from the state action list.
  function automatic logic [16:0] exp_ctrl(int s, int op, bit z, bit ir, bit dr);
    logic im, dm, rd, irw, pcw, sa, rw, m2r, hl, er;
    logic [1:0] pcs, sb;
    logic [2:0] aop;
    im = 0; dm = 0; rd = 1; irw = 0; pcw = 0; sa = 0; rw = 0; m2r = 0; hl = 0; er = 0;
    pcs = 0; sb = 0; aop = 0;
    case (s)
      0:  begin pcw = 1; pcs = 3; end
      1:  begin im = 1; sb = 1; irw = ir; pcw = ir; end
      2:  sb = 2;
      3:  begin sa = 1; aop = 3'(op % 4); end
      4, 5: begin sa = 1; sb = 2; end
      6:  begin dm = 1; rd = (op == 5); end
      7:  rw = 1;
      8:  begin rw = 1; m2r = 1; end
      9:  begin sa = 1; aop = 1; pcs = 1; pcw = (op == 7) ? z : !z; end
      10: begin pcw = 1; pcs = 2; end
      11: hl = 1;
      12: er = 1;
      default: ;
    endcase
    return {im, dm, rd, irw, pcw, pcs, sa, sb, aop, rw, m2r, hl, er};
  endfunction

  // One clock cycle: drive ready inputs, let them settle, compare, advance.
  task automatic step(input int s, input bit ir, input bit dr, input bit ret, input string tag);
    imem_ready = ir;
    dmem_ready = dr;
    #1;
    check({tag, " state"}, 32'(state_out), 32'(s));
    check({tag, " ctrl"}, 32'(ctrl), 32'(exp_ctrl(s, int'(opcode), zero, ir, dr)));
    check({tag, " retired"}, 32'(retired), 32'(exp_ret));
    if (ret) exp_ret = (exp_ret + 1) % (1 << RW);
    @(negedge clk);
  endtask

  task automatic add(input int s, input bit ir, input bit dr, input bit ret);
    sq.push_back(s); iq.push_back(ir); dq.push_back(dr); rq.push_back(ret);
  endtask

  task automatic play(input string tag);
    while (sq.size() > 0) step(sq.pop_front(), iq.pop_front(), dq.pop_front(), rq.pop_front(), tag);
  endtask

  // Plan one instruction from its class; unused ready inputs carry random noise.
  task automatic run_instr(input int op, input bit z, input int iw, input int dw, input string tag);
    opcode = OW'(op);
    zero   = z;
    for (int k = 0; k <= iw; k++) add(1, k == iw, 1'($urandom), 0);
    add(2, 1'($urandom), 1'($urandom), op == 15);
    if (op <= 3 || op == 4) begin
      add(op == 4 ? 4 : 3, 1'($urandom), 1'($urandom), 0);
      add(7, 1'($urandom), 1'($urandom), 1);
    end else if (op == 5 || op == 6) begin
      add(5, 1'($urandom), 1'($urandom), 0);
      for (int k = 0; k <= dw; k++) add(6, 1'($urandom), k == dw, (op == 6) && (k == dw));
      if (op == 5) add(8, 1'($urandom), 1'($urandom), 1);
    end else if (op == 7 || op == 8) begin
      add(9, 1'($urandom), 1'($urandom), 1);
    end else if (op == 9) begin
      add(10, 1'($urandom), 1'($urandom), 1);
    end else if (op == 15) begin
      add(11, 1'($urandom), 1'($urandom), 0);
      add(11, 1'($urandom), 1'($urandom), 0);
    end else begin
      add(12, 1'($urandom), 1'($urandom), 0);
      add(12, 1'($urandom), 1'($urandom), 0);
    end
    play(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    exp_ret = 0;
    check({tag, " async state"}, 32'(state_out), 32'(0));
    check({tag, " async ctrl"}, 32'(ctrl), 32'(exp_ctrl(0, 0, 0, 0, 0)));
    check({tag, " async retired"}, 32'(retired), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    step(0, 1'($urandom), 1'($urandom), 0, {tag, " init"});
  endtask

  initial begin
    @(negedge clk);
    do_reset("reset0");

    // Directed cases from the plan.
    run_instr(0, 0, 3, 0, "add_wait3");
    run_instr(5, 0, 0, 2, "lw_wait2");
    run_instr(6, 1, 1, 1, "sw_wait1");
    run_instr(7, 1, 0, 0, "beq_z1");
    run_instr(8, 1, 0, 0, "bne_z1");
    run_instr(5, 0, 4, 4, "lw_ready_at_limit");

    // Random legal, non-terminal instructions; retired wraps along the way.
    for (int n = 0; n < 40; n++)
      run_instr($urandom_range(0, 9), 1'($urandom), $urandom_range(0, TO), $urandom_range(0, TO), "rand");

    // Data memory never ready: five MEM_ACCESS cycles, then ERROR.
    opcode = OW'(5);
    add(1, 1, 0, 0);
    add(2, 0, 0, 0);
    add(5, 0, 0, 0);
    for (int k = 0; k <= TO; k++) add(6, 1'($urandom), 0, 0);
    add(12, 1'($urandom), 1'($urandom), 0);
    add(12, 1'($urandom), 1'($urandom), 0);
    play("dmem_timeout");
    do_reset("reset1");

    // Instruction memory never ready.
    for (int k = 0; k <= TO; k++) add(1, 0, 1'($urandom), 0);
    add(12, 0, 0, 0);
    play("imem_timeout");
    do_reset("reset2");

    run_instr(12, 0, 0, 0, "illegal12");
    do_reset("reset3");
    run_instr(0, 0, 0, 0, "add_pre_halt");
    run_instr(15, 0, 1, 0, "halt");
    do_reset("reset4");

    // Reset in the middle of a data access.
    run_instr(3, 0, 0, 0, "or_pre_mid");
    opcode = OW'(5);
    add(1, 1, 0, 0);
    add(2, 0, 0, 0);
    add(5, 0, 0, 0);
    add(6, 0, 0, 0);
    play("lw_mid");
    dmem_ready = 1'b0;
    #2;
    do_reset("reset_mid");
    run_instr(1, 0, 0, 0, "sub_after_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Parametrised multi-cycle control sequencer. It is the next-generation controller for the 24-bit multi-cycle computer.
- It drives IR/PC/regfile/ALU-mux/memory control from the current instruction's opcode.
- It adds variable-latency request/ready handshakes for instruction and data memory, a wait timeout, HALT/illegal-opcode terminal states and a retired-instruction counter.
- It sits between the instruction register/decoder and the datapath muxes.

Parameters:
- OPCODE_WIDTH, 4, opcode field width (the low 4 bits of the opcode are decoded; must be >= 4)
- MEM_TIMEOUT, 15, maximum wait cycles on any memory request; 0 disables the timeout
- RETIRE_WIDTH, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  OPCODE_WIDTH  opcode from instruction decoder (IR output)
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- mem_read_not_write  out  1  1=read, 0=write
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_source  out  2  0=ALU result, 1=ALU-out register, 2=jump address, 3=reset address
- alu_src_a  out  1  0=PC, 1=regA
- alu_src_b  out  2  0=regB, 1=const 1, 2=sign-extended imm, 3=const 1023
- alu_op  out  3  0=ADD, 1=SUB, 2=AND, 3=OR
- reg_write  out  1  regfile write enable
- mem_to_reg  out  1  1=memory register, 0=ALU-out register
- state_out  out  4  current state encoding
- halted  out  1  in HALTED
- error  out  1  in ERROR
- retired  out  RETIRE_WIDTH  retired-instruction count

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR (R-type)
  - 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J, 15 HALT
  - 10-14 illegal
- States and state_out encoding: INIT=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_ACCESS=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, HALTED=11, ERROR=12.
- Reset (async): state=INIT, wait counter=0, retired=0.
- Default output values: all outputs 0, except mem_read_not_write=1 and pc_source=0, whenever a state does not drive them.
- State actions and transitions:
  - INIT: pc_write=1, pc_source=3 -> FETCH.
  - FETCH: imem_req=1, alu_src_a=0, alu_src_b=1, alu_op=ADD.
    - If imem_ready: ir_write=1, pc_write=1, pc_source=0 (same cycle, Mealy) -> DECODE.
    - Otherwise stay in FETCH.
  - DECODE: alu_src_a=0, alu_src_b=2, ADD (branch target into ALU-out). Next state by opcode:
    - 0-3 -> EXEC_R; 4 -> EXEC_I; 5,6 -> MEM_ADDR; 7,8 -> BRANCH; 9 -> JUMP
    - 15 -> HALTED (counts retire); else -> ERROR
  - EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=opcode[1:0] -> WB_ALU.
  - EXEC_I: alu_src_a=1, alu_src_b=2, ADD -> WB_ALU.
  - WB_ALU: reg_write=1, mem_to_reg=0 -> FETCH, retire.
  - MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD -> MEM_ACCESS.
  - MEM_ACCESS: dmem_req=1, mem_read_not_write=(opcode==5).
    - On dmem_ready: LW -> WB_MEM; SW -> FETCH, retire.
    - Otherwise stay.
  - WB_MEM: reg_write=1, mem_to_reg=1 -> FETCH, retire.
  - BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1.
    - pc_write = zero (BEQ) or !zero (BNE).
    - -> FETCH, retire.
  - JUMP: pc_write=1, pc_source=2 -> FETCH, retire.
  - HALTED: halted=1; stays until reset.
  - ERROR: error=1; stays until reset.
- Wait counter:
  - Counts cycles in FETCH/MEM_ACCESS with ready low; cleared on every state change.
  - If MEM_TIMEOUT!=0 and the counter equals MEM_TIMEOUT while ready is still low -> ERROR next cycle. Requests deassert in ERROR.
  - Ready arriving in the same cycle the counter hits MEM_TIMEOUT wins (normal transition).
- retired:
  - Increments by 1 on the cycle of the retiring transition.
  - Wraps modulo 2^RETIRE_WIDTH.
  - Held in HALTED/ERROR.
- opcode is sampled combinationally; the IR holds it stable from DECODE until the next FETCH completes.
- Reset asserted mid-handshake: outputs go to INIT values immediately (async); an outstanding request is abandoned.

Test Plan:
- Reset pulse, release -> state_out=0 for one cycle with pc_write=1, pc_source=3; then state_out=1 with imem_req=1.
- ADD (opcode 0), imem_ready held low 3 cycles -> FETCH lasts 4 cycles, ir_write/pc_write pulse only on the ready cycle; states 1,2,3,7,1; retired 0->1; reg_write=1 only in WB_ALU.
- LW (5), dmem_ready after 2 wait cycles -> dmem_req=1 and mem_read_not_write=1 for 3 cycles; then WB_MEM with mem_to_reg=1, reg_write=1. SW (6) -> mem_read_not_write=0, no reg_write, returns to FETCH.
- BEQ with zero=1 -> pc_write=1, pc_source=1 in BRANCH. BNE with zero=1 -> pc_write=0. Both retire.
- MEM_TIMEOUT=4, dmem_ready never asserted -> ERROR after 5 MEM_ACCESS cycles, error=1, dmem_req=0, retired frozen. Repeat with ready on the 5th cycle -> no error.
- Opcode 12 -> ERROR. Opcode 15 -> HALTED, halted=1, retired +1. Reset asserted mid-MEM_ACCESS -> immediate state_out=0, dmem_req=0, retired=0.
